// File: rtl/decomp_bit_aligner_if.sv
// Stream, window and decode-step signals between the bit aligner, its word source
// and the length_generator loop.
interface decomp_bit_aligner_if #(
    parameter int IN_W   = 32,
    parameter int LENGTH = 6,
    parameter int WIN_W  = 68
);
    logic [IN_W-1:0]   i_data;
    logic              i_valid;
    logic              i_last;
    logic              o_ready;
    logic [WIN_W-1:0]  o_window;
    logic              o_window_valid;
    logic [LENGTH-1:0] i_length1;
    logic [LENGTH-1:0] i_length2;
    logic              i_consume;
    logic [7:0]        o_bit_count;
    logic              o_err;

    modport slave (
        input  i_data, i_valid, i_last, i_length1, i_length2, i_consume,
        output o_ready, o_window, o_window_valid, o_bit_count, o_err
    );

    modport master (
        output i_data, i_valid, i_last, i_length1, i_length2, i_consume,
        input  o_ready, o_window, o_window_valid, o_bit_count, o_err
    );
endinterface

// File: rtl/decomp_bit_aligner.sv
// MSB-aligned bit buffer: refills 32-bit words and retires length1+length2 bits
// per decode step, both in the same cycle.
module decomp_bit_aligner #(
    parameter int IN_W   = 32,
    parameter int BUF_W  = 128,
    parameter int LENGTH = 6,
    parameter int WIN_W  = 68
) (
    input  logic                   i_clk,
    input  logic                   i_reset,
    decomp_bit_aligner_if.slave    bus
);
    logic [BUF_W-1:0] r_buf;
    logic [7:0]       r_count;
    logic             r_last_seen;
    logic             r_err;

    logic [LENGTH:0]  w_total;
    logic             w_ready;
    logic             w_win_valid;
    logic             w_acc;
    logic             w_con;
    logic             w_over;
    logic [7:0]       w_ret;
    logic [7:0]       w_off;
    logic [BUF_W-1:0] w_ins;
    logic [BUF_W-1:0] w_next_buf;
    logic [7:0]       w_next_count;

    assign w_total     = {1'b0, bus.i_length1} + {1'b0, bus.i_length2};
    // Admitting only at count <= BUF_W-IN_W guarantees the word fits even with no retire.
    assign w_ready     = !i_reset && !r_last_seen && (r_count <= 8'(BUF_W - IN_W));
    assign w_win_valid = (r_count >= 8'(WIN_W)) || (r_last_seen && r_count != 8'd0);
    assign w_acc       = bus.i_valid && w_ready;
    assign w_con       = bus.i_consume && w_win_valid;
    assign w_over      = 8'(w_total) > r_count;
    assign w_ret       = w_con ? (w_over ? r_count : 8'(w_total)) : 8'd0;
    assign w_off       = r_count - w_ret;
    assign w_ins       = w_acc ? ({bus.i_data, {(BUF_W-IN_W){1'b0}}} >> w_off) : '0;
    assign w_next_buf  = (r_buf << w_ret) | w_ins;
    assign w_next_count = w_off + (w_acc ? 8'(IN_W) : 8'd0);

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_buf       <= '0;
            r_count     <= 8'd0;
            r_last_seen <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_buf   <= w_next_buf;
            r_count <= w_next_count;
            if (w_con && w_over)
                r_err <= 1'b1;
            // Draining to empty re-opens the input for the next block.
            if (r_last_seen && w_next_count == 8'd0)
                r_last_seen <= 1'b0;
            else if (w_acc && bus.i_last)
                r_last_seen <= 1'b1;
        end
    end

    assign bus.o_ready        = w_ready;
    assign bus.o_window       = r_buf[BUF_W-1 -: WIN_W];
    assign bus.o_window_valid = w_win_valid;
    assign bus.o_bit_count    = r_count;
    assign bus.o_err          = r_err;
endmodule

// File: tb/tb_decomp_bit_aligner.sv
// Directed bench for decomp_bit_aligner: reset, fill, concurrent refill/retire,
// maximum retire, drain with overrun, and ignored consume.
module tb_decomp_bit_aligner;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;

    decomp_bit_aligner_if #(.IN_W(32), .LENGTH(6), .WIN_W(68)) bus ();

    decomp_bit_aligner #(.IN_W(32), .BUF_W(128), .LENGTH(6), .WIN_W(68)) dut (
        .i_clk  (clk),
        .i_reset(rst),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.i_valid   = 1'b0;
        bus.i_last    = 1'b0;
        bus.i_consume = 1'b0;
        bus.i_data    = 32'h0;
        bus.i_length1 = 6'd0;
        bus.i_length2 = 6'd0;
    endtask

    task automatic push(input logic [31:0] d, input logic last);
        bus.i_valid = 1'b1;
        bus.i_data  = d;
        bus.i_last  = last;
        step();
        idle();
    endtask

    task automatic consume(input logic [5:0] l1, input logic [5:0] l2);
        bus.i_consume = 1'b1;
        bus.i_length1 = l1;
        bus.i_length2 = l2;
        step();
        idle();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.i_valid = 1'b1; bus.i_data = 32'hFFFFFFFF; bus.i_consume = 1'b1;
        bus.i_length1 = 6'd4; bus.i_length2 = 6'd4; bus.i_last = 1'b1;
        step(); step();
        total++; if (bus.o_window !== 68'h0) begin bad++; $display("FAIL rst_window got=%h exp=0", bus.o_window); end
        total++; if (bus.o_window_valid !== 1'b0) begin bad++; $display("FAIL rst_wvalid got=%b exp=0", bus.o_window_valid); end
        total++; if (bus.o_bit_count !== 8'd0) begin bad++; $display("FAIL rst_count got=%0d exp=0", bus.o_bit_count); end
        total++; if (bus.o_err !== 1'b0) begin bad++; $display("FAIL rst_err got=%b exp=0", bus.o_err); end
        total++; if (bus.o_ready !== 1'b0) begin bad++; $display("FAIL rst_ready got=%b exp=0", bus.o_ready); end
        idle();
        rst = 1'b0;
        #1;
        total++; if (bus.o_ready !== 1'b1) begin bad++; $display("FAIL rst_release_ready got=%b exp=1", bus.o_ready); end
    endtask

    task automatic test_fill();
        push(32'hC0000000, 1'b0);
        total++; if (bus.o_bit_count !== 8'd32) begin bad++; $display("FAIL fill_cnt32 got=%0d exp=32", bus.o_bit_count); end
        push(32'h12345678, 1'b0);
        total++; if (bus.o_window_valid !== 1'b0) begin bad++; $display("FAIL fill_wvalid64 got=%b exp=0", bus.o_window_valid); end
        push(32'h9ABCDEF0, 1'b0);
        total++; if (bus.o_bit_count !== 8'd96) begin bad++; $display("FAIL fill_cnt96 got=%0d exp=96", bus.o_bit_count); end
        total++; if (bus.o_window_valid !== 1'b1) begin bad++; $display("FAIL fill_wvalid96 got=%b exp=1", bus.o_window_valid); end
        total++; if (bus.o_window !== {32'hC0000000, 32'h12345678, 4'h9}) begin bad++; $display("FAIL fill_window got=%h exp=%h", bus.o_window, {32'hC0000000, 32'h12345678, 4'h9}); end
        total++; if (bus.o_ready !== 1'b1) begin bad++; $display("FAIL fill_ready96 got=%b exp=1", bus.o_ready); end
        push(32'h0F0F0F0F, 1'b0);
        total++; if (bus.o_bit_count !== 8'd128) begin bad++; $display("FAIL fill_cnt128 got=%0d exp=128", bus.o_bit_count); end
        total++; if (bus.o_ready !== 1'b0) begin bad++; $display("FAIL fill_ready128 got=%b exp=0", bus.o_ready); end
        // valid while full must be dropped
        push(32'hBAD0BAD0, 1'b0);
        total++; if (bus.o_bit_count !== 8'd128) begin bad++; $display("FAIL fill_full_drop got=%0d exp=128", bus.o_bit_count); end
    endtask

    task automatic test_concurrent();
        consume(6'd16, 6'd16);
        total++; if (bus.o_bit_count !== 8'd96) begin bad++; $display("FAIL conc_cnt96 got=%0d exp=96", bus.o_bit_count); end
        total++; if (bus.o_window !== {32'h12345678, 32'h9ABCDEF0, 4'h0}) begin bad++; $display("FAIL conc_window96 got=%h", bus.o_window); end
        bus.i_valid = 1'b1; bus.i_data = 32'hFFFFFFFF;
        consume(6'd2, 6'd34);
        total++; if (bus.o_bit_count !== 8'd92) begin bad++; $display("FAIL conc_cnt92 got=%0d exp=92", bus.o_bit_count); end
        total++; if (bus.o_window !== {28'hABCDEF0, 32'h0F0F0F0F, 8'hFF}) begin bad++; $display("FAIL conc_window92 got=%h exp=%h", bus.o_window, {28'hABCDEF0, 32'h0F0F0F0F, 8'hFF}); end
        consume(6'd30, 6'd30);
        total++; if (bus.o_bit_count !== 8'd32) begin bad++; $display("FAIL conc_cnt32 got=%0d exp=32", bus.o_bit_count); end
        total++; if (bus.o_window !== {32'hFFFFFFFF, 36'h0}) begin bad++; $display("FAIL conc_newword got=%h", bus.o_window); end
        total++; if (bus.o_window_valid !== 1'b0) begin bad++; $display("FAIL conc_wvalid32 got=%b exp=0", bus.o_window_valid); end
    endtask

    task automatic test_max_retire();
        push(32'hA5A5A5A5, 1'b0);
        push(32'h3C3C3C3C, 1'b0);
        consume(6'd14, 6'd14);
        total++; if (bus.o_bit_count !== 8'd68) begin bad++; $display("FAIL max_cnt68 got=%0d exp=68", bus.o_bit_count); end
        total++; if (bus.o_window !== {4'hF, 32'hA5A5A5A5, 32'h3C3C3C3C}) begin bad++; $display("FAIL max_window68 got=%h", bus.o_window); end
        consume(6'd34, 6'd34);
        total++; if (bus.o_bit_count !== 8'd0) begin bad++; $display("FAIL max_cnt0 got=%0d exp=0", bus.o_bit_count); end
        total++; if (bus.o_window_valid !== 1'b0) begin bad++; $display("FAIL max_wvalid got=%b exp=0", bus.o_window_valid); end
        total++; if (bus.o_err !== 1'b0) begin bad++; $display("FAIL max_err got=%b exp=0", bus.o_err); end
        total++; if (bus.o_window !== 68'h0) begin bad++; $display("FAIL max_window0 got=%h exp=0", bus.o_window); end
    endtask

    task automatic test_drain_err();
        push(32'hDEADBEEF, 1'b0);
        push(32'hCAFEF00D, 1'b1);
        total++; if (bus.o_bit_count !== 8'd64) begin bad++; $display("FAIL drain_cnt64 got=%0d exp=64", bus.o_bit_count); end
        total++; if (bus.o_window_valid !== 1'b1) begin bad++; $display("FAIL drain_wvalid64 got=%b exp=1", bus.o_window_valid); end
        total++; if (bus.o_ready !== 1'b0) begin bad++; $display("FAIL drain_ready_last got=%b exp=0", bus.o_ready); end
        total++; if (bus.o_window !== {32'hDEADBEEF, 32'hCAFEF00D, 4'h0}) begin bad++; $display("FAIL drain_window64 got=%h", bus.o_window); end
        consume(6'd6, 6'd2);
        total++; if (bus.o_bit_count !== 8'd56) begin bad++; $display("FAIL drain_cnt56 got=%0d exp=56", bus.o_bit_count); end
        total++; if (bus.o_window !== {24'hADBEEF, 32'hCAFEF00D, 12'h0}) begin bad++; $display("FAIL drain_window56 got=%h", bus.o_window); end
        total++; if (bus.o_err !== 1'b0) begin bad++; $display("FAIL drain_err_early got=%b exp=0", bus.o_err); end
        consume(6'd34, 6'd24);
        total++; if (bus.o_bit_count !== 8'd0) begin bad++; $display("FAIL drain_cnt0 got=%0d exp=0", bus.o_bit_count); end
        total++; if (bus.o_err !== 1'b1) begin bad++; $display("FAIL drain_err got=%b exp=1", bus.o_err); end
        total++; if (bus.o_ready !== 1'b1) begin bad++; $display("FAIL drain_ready_reopen got=%b exp=1", bus.o_ready); end
        total++; if (bus.o_window_valid !== 1'b0) begin bad++; $display("FAIL drain_wvalid0 got=%b exp=0", bus.o_window_valid); end
        step();
        total++; if (bus.o_err !== 1'b1) begin bad++; $display("FAIL drain_err_sticky got=%b exp=1", bus.o_err); end
    endtask

    task automatic test_invalid_consume();
        rst = 1'b1;
        step();
        rst = 1'b0;
        total++; if (bus.o_err !== 1'b0) begin bad++; $display("FAIL inv_err_cleared got=%b exp=0", bus.o_err); end
        push(32'h01234567, 1'b0);
        push(32'h89ABCDEF, 1'b0);
        push(32'h76543210, 1'b0);
        consume(6'd28, 6'd28);
        total++; if (bus.o_bit_count !== 8'd40) begin bad++; $display("FAIL inv_cnt40 got=%0d exp=40", bus.o_bit_count); end
        total++; if (bus.o_window_valid !== 1'b0) begin bad++; $display("FAIL inv_wvalid40 got=%b exp=0", bus.o_window_valid); end
        // last without valid must not mark the block finished
        bus.i_last = 1'b1;
        consume(6'd8, 6'd8);
        total++; if (bus.o_bit_count !== 8'd40) begin bad++; $display("FAIL inv_cnt_hold got=%0d exp=40", bus.o_bit_count); end
        total++; if (bus.o_err !== 1'b0) begin bad++; $display("FAIL inv_err got=%b exp=0", bus.o_err); end
        total++; if (bus.o_ready !== 1'b1) begin bad++; $display("FAIL inv_ready got=%b exp=1", bus.o_ready); end
        total++; if (bus.o_window_valid !== 1'b0) begin bad++; $display("FAIL inv_wvalid_hold got=%b exp=0", bus.o_window_valid); end
    endtask

    initial begin
        idle();
        test_reset();
        test_fill();
        test_concurrent();
        test_max_retire();
        test_drain_err();
        test_invalid_consume();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
